sprite_compositor: RTL and testbench

//  Pixel-stage consumer of the VGA timing driver. Takes its per-pixel request address (x,y) and disp/v_sync,

---
 rtl/sprite_compositor.sv | 146 ++++++++++++++
 tb/tb_sprite_compositor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// sprite_compositor
// Pixel-stage consumer of the VGA timing driver. Overlays one sprite, read
// from a synchronous sprite ROM, onto the background pixel stream and drives
// RGB444. The sprite position is staged in a shadow register by game logic
// and committed on the rising edge of v_sync, so the plane never tears within
// a frame. Two-clock pipeline to match the driver's 2-cycle address lead.
module sprite_compositor #(
    parameter int          X_W       = 10,
    parameter int          Y_W       = 10,
    parameter int          SPR_W     = 32,
    parameter int          SPR_H     = 32,
    parameter int          ADDR_W    = 10,
    parameter logic [11:0] TRANS_KEY = 12'hF0F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [X_W-1:0]    x_i,
    input  logic [Y_W-1:0]    y_i,
    input  logic              disp_i,
    input  logic              v_sync_i,
    input  logic [X_W-1:0]    pos_x_i,
    input  logic [Y_W-1:0]    pos_y_i,
    input  logic              pos_vld_i,
    input  logic [11:0]       bg_rgb_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [11:0]       rom_data_i,
    output logic [11:0]       rgb_o,
    output logic              frame_o
);

    localparam int SX = $clog2(SPR_W);
    localparam int SY = $clog2(SPR_H);
    localparam logic [X_W-1:0] SPR_W_L = X_W'(SPR_W);
    localparam logic [Y_W-1:0] SPR_H_L = Y_W'(SPR_H);

    // Position double buffer
    logic [X_W-1:0]    shadow_x;
    logic [Y_W-1:0]    shadow_y;
    logic              shadow_vld;
    logic [X_W-1:0]    act_x;
    logic [Y_W-1:0]    act_y;
    logic              spr_en;

    // Frame-commit detection
    logic              v_sync_q;
    logic              commit;

    // Pixel pipeline
    logic [X_W:0]      dx;
    logic [Y_W:0]      dy;
    logic              hit;
    logic              hit_q;
    logic [ADDR_W-1:0] addr_next;
    logic [11:0]       pix_q;

    // Hit test against the active sprite box and ROM address formation
    always_comb begin
        dx        = {1'b0, x_i} - {1'b0, act_x};
        dy        = {1'b0, y_i} - {1'b0, act_y};
        commit    = en_i & v_sync_i & ~v_sync_q;
        // A borrow in the top bit means the pixel is left of / above the sprite.
        hit       = spr_en & ~dx[X_W] & ~dy[Y_W]
                    & (dx[X_W-1:0] < SPR_W_L) & (dy[Y_W-1:0] < SPR_H_L);
        addr_next = '0;
        if (hit) begin
            addr_next = ADDR_W'({dy[SY-1:0], dx[SX-1:0]});
        end else begin
            addr_next = '0;
        end
    end

    // v_sync sampler; held high while disabled so re-enabling never looks like an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_sync_q <= 1'b1;
        end else if (!en_i) begin
            v_sync_q <= 1'b1;
        end else begin
            v_sync_q <= v_sync_i;
        end
    end

    // Shadow capture from game logic; a new strobe wins over the commit clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_x   <= '0;
            shadow_y   <= '0;
            shadow_vld <= 1'b0;
        end else if (pos_vld_i) begin
            shadow_x   <= pos_x_i;
            shadow_y   <= pos_y_i;
            shadow_vld <= 1'b1;
        end else if (commit) begin
            shadow_vld <= 1'b0;
        end
    end

    // Commit the pending shadow into the active position once per frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_x   <= '0;
            act_y   <= '0;
            spr_en  <= 1'b0;
            frame_o <= 1'b0;
        end else begin
            frame_o <= commit;
            if (commit && shadow_vld) begin
                act_x  <= shadow_x;
                act_y  <= shadow_y;
                spr_en <= 1'b1;
            end
        end
    end

    // Two-stage pixel pipeline: ROM address, then sprite/background select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_o <= '0;
            hit_q      <= 1'b0;
            pix_q      <= 12'h000;
        end else if (!en_i) begin
            rom_addr_o <= '0;
            hit_q      <= 1'b0;
            pix_q      <= 12'h000;
        end else begin
            rom_addr_o <= addr_next;
            hit_q      <= hit;
            if (hit_q && (rom_data_i != TRANS_KEY)) begin
                pix_q <= rom_data_i;
            end else begin
                pix_q <= bg_rgb_i;
            end
        end
    end

    // Blanking gate on the registered pixel
    always_comb begin
        if (disp_i) begin
            rgb_o = pix_q;
        end else begin
            rgb_o = 12'h000;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: background pass-through, sprite hit
// box and ROM addressing, transparency, screen-edge clipping, frame commit
// ordering, and behaviour across disable / mid-frame reset.
module tb_sprite_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_i;
    logic [9:0]  x_i;
    logic [9:0]  y_i;
    logic        disp_i;
    logic        v_sync_i;
    logic [9:0]  pos_x_i;
    logic [9:0]  pos_y_i;
    logic        pos_vld_i;
    logic [11:0] bg_rgb_i;
    logic [9:0]  rom_addr_o;
    logic [11:0] rom_data_i;
    logic [11:0] rgb_o;
    logic        frame_o;

    logic [11:0] bg_base;
    logic        rom_trans;

    int vectors     = 0;
    int miscompares = 0;

    sprite_compositor dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_i),
        .x_i        (x_i),
        .y_i        (y_i),
        .disp_i     (disp_i),
        .v_sync_i   (v_sync_i),
        .pos_x_i    (pos_x_i),
        .pos_y_i    (pos_y_i),
        .pos_vld_i  (pos_vld_i),
        .bg_rgb_i   (bg_rgb_i),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_data_i),
        .rgb_o      (rgb_o),
        .frame_o    (frame_o)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] bg_fn(input logic [9:0] x, input logic [9:0] y);
        return bg_base ^ {x[5:0], y[5:0]};
    endfunction

    // Background BRAM model: one-cycle registered read
    always @(posedge clk) bg_rgb_i <= bg_fn(x_i, y_i);

    // Sprite ROM data for the currently registered address
    assign rom_data_i = rom_trans ? 12'hF0F : (12'hABC ^ {2'b00, rom_addr_o});

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one pixel, check the address after stage 1 and the pixel after stage 2
    task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic [9:0] exp_addr, input logic [11:0] exp_rgb);
        @(negedge clk);
        x_i = x;
        y_i = y;
        @(posedge clk);
        #1 check({tag, "_addr"}, {6'd0, rom_addr_o}, {6'd0, exp_addr});
        @(negedge clk);
        x_i = 10'd1023;
        y_i = 10'd1023;
        @(posedge clk);
        #1 check({tag, "_rgb"}, {4'd0, rgb_o}, {4'd0, exp_rgb});
    endtask

    task automatic strobe(input logic [9:0] px, input logic [9:0] py);
        @(negedge clk);
        pos_x_i   = px;
        pos_y_i   = py;
        pos_vld_i = 1'b1;
        @(negedge clk);
        pos_vld_i = 1'b0;
    endtask

    // Sync pulse; optionally strobe a new position on the rising-edge cycle
    task automatic vsync(input logic with_strobe, input logic [9:0] px, input logic [9:0] py);
        @(negedge clk);
        v_sync_i = 1'b0;
        repeat (3) @(negedge clk);
        v_sync_i = 1'b1;
        if (with_strobe) begin
            pos_x_i   = px;
            pos_y_i   = py;
            pos_vld_i = 1'b1;
        end
        @(posedge clk);
        #1 check("frame_pulse", {15'd0, frame_o}, 16'd1);
        @(negedge clk);
        pos_vld_i = 1'b0;
        @(posedge clk);
        #1 check("frame_clear", {15'd0, frame_o}, 16'd0);
    endtask

    initial begin
        rst       = 1'b1;
        en_i      = 1'b1;
        x_i       = 10'd0;
        y_i       = 10'd0;
        disp_i    = 1'b1;
        v_sync_i  = 1'b1;
        pos_x_i   = 10'd0;
        pos_y_i   = 10'd0;
        pos_vld_i = 1'b0;
        bg_base   = 12'h123;
        rom_trans = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", {6'd0, rom_addr_o}, 16'd0);
        check("rst_rgb", {4'd0, rgb_o}, 16'd0);
        check("rst_frame", {15'd0, frame_o}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: no position ever committed -> background only, blanking forced
        pixel("bg0", 10'd0, 10'd0, 10'd0, 12'h123);
        pixel("bg1", 10'd100, 10'd50, 10'd0, bg_fn(10'd100, 10'd50));
        disp_i = 1'b0;
        pixel("blank", 10'd100, 10'd50, 10'd0, 12'h000);
        disp_i = 1'b1;
        vsync(1'b0, 10'd0, 10'd0);
        pixel("noshow", 10'd0, 10'd0, 10'd0, 12'h123);

        // 2: position (100,50) staged, visible only after the next commit
        strobe(10'd100, 10'd50);
        pixel("pend", 10'd100, 10'd50, 10'd0, bg_fn(10'd100, 10'd50));
        vsync(1'b0, 10'd0, 10'd0);
        pixel("tl", 10'd100, 10'd50, 10'd0, 12'hABC);
        pixel("br", 10'd131, 10'd81, 10'd1023, 12'h943);
        pixel("right", 10'd132, 10'd50, 10'd0, bg_fn(10'd132, 10'd50));
        pixel("left", 10'd99, 10'd50, 10'd0, bg_fn(10'd99, 10'd50));
        pixel("below", 10'd100, 10'd82, 10'd0, bg_fn(10'd100, 10'd82));

        // 3: transparent key shows the background
        rom_trans = 1'b1;
        pixel("trans", 10'd110, 10'd60, 10'd330, bg_fn(10'd110, 10'd60));
        rom_trans = 1'b0;

        // 4: sprite clipped at the bottom-right corner, no wrap to zero
        strobe(10'd624, 10'd470);
        vsync(1'b0, 10'd0, 10'd0);
        pixel("edge_tl", 10'd624, 10'd470, 10'd0, 12'hABC);
        pixel("edge_br", 10'd639, 10'd479, 10'd303, 12'hB93);
        pixel("nowrap00", 10'd0, 10'd0, 10'd0, bg_fn(10'd0, 10'd0));
        pixel("nowrapx", 10'd0, 10'd470, 10'd0, bg_fn(10'd0, 10'd470));
        pixel("nowrapy", 10'd624, 10'd0, 10'd0, bg_fn(10'd624, 10'd0));

        // 5: strobe on the commit cycle -> old shadow now, new one next frame
        strobe(10'd200, 10'd100);
        vsync(1'b1, 10'd300, 10'd200);
        pixel("old_in", 10'd200, 10'd100, 10'd0, 12'hABC);
        pixel("new_out", 10'd300, 10'd200, 10'd0, bg_fn(10'd300, 10'd200));
        vsync(1'b0, 10'd0, 10'd0);
        pixel("new_in", 10'd301, 10'd201, 10'd33, 12'hABC ^ 12'h021);
        pixel("old_out", 10'd200, 10'd100, 10'd0, bg_fn(10'd200, 10'd100));

        // 6: disable mid-line, reset in the middle, sync toggling throughout
        @(negedge clk);
        x_i  = 10'd300;
        y_i  = 10'd200;
        en_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            check("off_rgb", {4'd0, rgb_o}, 16'd0);
            check("off_addr", {6'd0, rom_addr_o}, 16'd0);
            check("off_frame", {15'd0, frame_o}, 16'd0);
            @(negedge clk);
            v_sync_i = ((i % 10) < 3) ? 1'b0 : 1'b1;
            rst      = (i >= 40 && i < 50) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        rst      = 1'b0;
        v_sync_i = 1'b1;
        en_i     = 1'b1;
        @(posedge clk);
        #1 check("reen_frame", {15'd0, frame_o}, 16'd0);
        pixel("hid0", 10'd300, 10'd200, 10'd0, bg_fn(10'd300, 10'd200));
        vsync(1'b0, 10'd0, 10'd0);
        pixel("hid1", 10'd300, 10'd200, 10'd0, bg_fn(10'd300, 10'd200));
        pixel("hid2", 10'd0, 10'd0, 10'd0, 12'h123);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
